// File: rtl/arbiter_pkg.sv
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared definitions for the eight-way round-robin arbiter:
//               requester count, index width, FSM state encoding, hold-counter
//               width and the default grant-hold limit.
// Optional    : ARB_TIMEOUT_EN (consumed by round_robin_arbiter, not here)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_pkg;

  // Number of requesters and width of a requester index.
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Width of the grant-hold counter (covers TIMEOUT_CYCLES up to 255).
  localparam int HOLD_CNT_W = 8;

  // Default maximum grant hold length, in cycles.
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Next index in the circular search order (7 wraps to 0).
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage : arbiter_pkg

`default_nettype wire

// File: rtl/onehot_decoder_3to8.sv
// ============================================================================
// Module      : onehot_decoder_3to8
// Description : Purely combinational 3-to-8 binary-to-one-hot decoder used to
//               build the arbiter grant vector from the owner index.
// Ports       : idx_i    [2:0]  binary index
//               onehot_o [7:0]  one-hot image of idx_i (exactly one bit set)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder_3to8
  import arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  for (genvar i = 0; i < N_REQ; i++) begin : g_bit
    assign onehot_o[i] = (idx_i == IDX_W'(i));
  end

endmodule : onehot_decoder_3to8

`default_nettype wire

// File: rtl/round_robin_arbiter.sv
// ============================================================================
// Module      : round_robin_arbiter
// Description : Eight-way round-robin arbiter for one shared resource.
//               A rotating pointer marks the highest-priority requester; the
//               first active request found from the pointer onwards wins and
//               keeps the grant until it drops its request (no preemption).
//               On release the pointer moves to the owner + 1, and one idle
//               cycle with an all-zero grant always separates two owners.
// Optional    : ARB_TIMEOUT_EN - when defined, a grant held for
//               TIMEOUT_CYCLES cycles is revoked and 'timeout' pulses for one
//               cycle. When undefined, grants are held indefinitely and
//               'timeout' is tied low.
// Parameters  : TIMEOUT_CYCLES  maximum grant hold length (2..255)
// Ports       : clk          rising-edge clock
//               reset        synchronous active-high reset
//               req[7:0]     level-sensitive request vector
//               grant[7:0]   registered one-hot grant, zero when idle
//               grant_idx    binary owner index, valid while grant_valid=1
//               grant_valid  high while a grant is held
//               timeout      one-cycle pulse when a grant is revoked
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter check
  // --------------------------------------------------------------------------
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("round_robin_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_valid_q;
  logic [N_REQ-1:0] grant_q;

  // Next-state values that feed the decoder and the output registers.
  logic [IDX_W-1:0] grant_idx_d;
  logic             grant_valid_d;
  logic [N_REQ-1:0] grant_d;

  // Rotating priority search results.
  logic [IDX_W-1:0] search_cand;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  // Owner still requesting, and forced-release condition.
  logic             owner_req;
  logic             hold_expired;

  logic [N_REQ-1:0] decoded_idx;

  // --------------------------------------------------------------------------
  // Rotating priority search: visit ptr, ptr+1, ... ptr+7 (mod 8) and keep
  // the first active request. The 3-bit add wraps naturally from 7 to 0.
  // --------------------------------------------------------------------------
  always_comb begin
    search_cand = '0;
    pick_idx    = ptr_q;
    pick_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      search_cand = ptr_q + IDX_W'(i);
      if (!pick_found && req[search_cand]) begin
        pick_found = 1'b1;
        pick_idx   = search_cand;
      end
    end
  end

  assign owner_req = req[grant_idx_q];

  // --------------------------------------------------------------------------
  // Optional grant-hold limit
  // --------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt_q;
  logic                  timeout_q;

  // Only meaningful in GRANT; the counter is cleared on every entry to GRANT.
  assign hold_expired = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST);
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next owner index / valid. These drive the decoder so that the registered
  // grant vector always lands on the same edge as grant_idx and grant_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
        end
      end
      GRANT: begin
        // A normal release and a forced release both drop the grant.
        if (!owner_req || hold_expired) begin
          grant_valid_d = 1'b0;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
      end
    endcase
  end

  onehot_decoder_3to8 u_onehot_decoder (
    .idx_i    (grant_idx_d),
    .onehot_o (decoded_idx)
  );

  // Gating keeps the grant all-zero whenever no owner is held.
  assign grant_d = decoded_idx & {N_REQ{grant_valid_d}};

  // --------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
`ifdef ARB_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        GRANT: begin
          if (!owner_req) begin
            // Normal release takes precedence over a coincident timeout.
            state_q <= IDLE;
            ptr_q   <= idx_next(grant_idx_q);
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_expired) begin
            state_q   <= IDLE;
            ptr_q     <= idx_next(grant_idx_q);
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule : round_robin_arbiter

`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
// ============================================================================
// Module      : tb_round_robin_arbiter
// Description : Self-checking bench for round_robin_arbiter. Directed
//               scenarios plus a randomized run, all compared against a
//               behavioural model of the arbitration rules. Build with
//               ARB_TIMEOUT_EN defined to exercise the grant-hold limit
//               (TIMEOUT_CYCLES=4 in that build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_robin_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: current owner (-1 = none), priority pointer, cycles
  // the owner has held the grant, and the timeout pulse expected this cycle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  round_robin_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_grant();
    return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
  endfunction

  // Apply one clock edge of the arbitration rules to the model.
  function automatic void model_step(input logic [7:0] r, input logic rst);
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TO_EN && m_held >= TO) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  // Drive inputs at the falling edge, advance the model at the rising edge,
  // and return 1 ns later so outputs are sampled away from the edge.
  task automatic tick(input logic [7:0] r, input logic rst);
    @(negedge clk);
    req   = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    #1;
  endtask

  task automatic test_reset();
    tick(8'hFF, 1'b1);
    tick(8'hFF, 1'b1);
    n_total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0 || timeout !== 1'b0)
      $display("FAIL reset: grant=%b valid=%b idx=%0d to=%b required 00000000/0/0/0",
               grant, grant_valid, grant_idx, timeout);
    else n_pass++;
  endtask

  task automatic test_basic();
    tick(8'h00, 1'b1);
    tick(8'b0000_0101, 1'b0);
    n_total++;
    if (grant !== 8'b0000_0001 || grant_idx !== 3'd0 || grant_valid !== 1'b1)
      $display("FAIL basic_first: grant=%b idx=%0d valid=%b required 00000001/0/1",
               grant, grant_idx, grant_valid);
    else n_pass++;
    tick(8'b0000_0100, 1'b0);
    n_total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0)
      $display("FAIL basic_gap: grant=%b valid=%b required 00000000/0", grant, grant_valid);
    else n_pass++;
    tick(8'b0000_0100, 1'b0);
    n_total++;
    if (grant !== 8'b0000_0100 || grant_idx !== 3'd2)
      $display("FAIL basic_second: grant=%b idx=%0d required 00000100/2", grant, grant_idx);
    else n_pass++;
    tick(8'h00, 1'b0);
  endtask

  task automatic test_rotation();
    logic [7:0] r;
    logic [7:0] exp;
    tick(8'h00, 1'b1);
    for (int k = 0; k < 18; k++) begin
      r = 8'hFF;
      if (m_owner >= 0) r[m_owner] = 1'b0;
      tick(r, 1'b0);
      exp = (k % 2 == 0) ? 8'(1 << ((k / 2) % 8)) : 8'h00;
      n_total++;
      if (grant !== exp)
        $display("FAIL rotation step %0d: grant=%b required %b", k, grant, exp);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    tick(8'h00, 1'b1);
    tick(8'h20, 1'b0);
    tick(8'h00, 1'b0);            // owner 5 releases, pointer -> 6
    tick(8'b0000_0011, 1'b0);
    n_total++;
    if (grant !== 8'b0000_0001 || grant_idx !== 3'd0)
      $display("FAIL wrap_grant: grant=%b idx=%0d required 00000001/0", grant, grant_idx);
    else n_pass++;
    tick(8'b0000_0010, 1'b0);     // owner 0 releases, pointer -> 1
    tick(8'b0000_0011, 1'b0);
    n_total++;
    if (grant !== 8'b0000_0010 || grant_idx !== 3'd1)
      $display("FAIL wrap_ptr: grant=%b idx=%0d required 00000010/1", grant, grant_idx);
    else n_pass++;
    tick(8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_grant();
    tick(8'h00, 1'b1);
    tick(8'h10, 1'b0);
    n_total++;
    if (grant !== 8'b0001_0000)
      $display("FAIL midreset_setup: grant=%b required 00010000", grant);
    else n_pass++;
    tick(8'hFF, 1'b1);
    n_total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0)
      $display("FAIL midreset_clear: grant=%b valid=%b required 00000000/0", grant, grant_valid);
    else n_pass++;
    tick(8'hFF, 1'b0);
    n_total++;
    if (grant !== 8'h01 || grant_idx !== 3'd0)
      $display("FAIL midreset_regrant: grant=%b idx=%0d required 00000001/0", grant, grant_idx);
    else n_pass++;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick(8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(8'h08, 1'b0);
      n_total++;
      if (grant !== 8'h08 || timeout !== 1'b0)
        $display("FAIL timeout_hold %0d: grant=%b to=%b required 00001000/0", k, grant, timeout);
      else n_pass++;
    end
    tick(8'h08, 1'b0);
    n_total++;
    if (grant !== 8'h00 || timeout !== 1'b1)
      $display("FAIL timeout_revoke: grant=%b to=%b required 00000000/1", grant, timeout);
    else n_pass++;
    tick(8'h08, 1'b0);
    n_total++;
    if (grant !== 8'h08 || timeout !== 1'b0)
      $display("FAIL timeout_regrant_alone: grant=%b to=%b required 00001000/0", grant, timeout);
    else n_pass++;
    repeat (3) tick(8'h08, 1'b0);
    tick(8'h0C, 1'b0);            // revoked again, pointer -> 4
    tick(8'h0C, 1'b0);
    n_total++;
    if (grant !== 8'h04)
      $display("FAIL timeout_other_wins: grant=%b required 00000100", grant);
    else n_pass++;
    repeat (3) tick(8'h0C, 1'b0);
    tick(8'h08, 1'b0);            // release and expiry coincide
    n_total++;
    if (grant !== 8'h00 || timeout !== 1'b0)
      $display("FAIL timeout_release_wins: grant=%b to=%b required 00000000/0", grant, timeout);
    else n_pass++;
  endtask
`else
  task automatic test_long_hold();
    tick(8'h00, 1'b1);
    tick(8'h04, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      tick(8'h04, 1'b0);
      n_total++;
      if (grant !== 8'h04 || timeout !== 1'b0)
        $display("FAIL long_hold cycle %0d: grant=%b to=%b required 00000100/0", k, grant, timeout);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] r;
    logic       rst;
    tick(8'h00, 1'b1);
    for (int k = 0; k < 600; k++) begin
      r = 8'($urandom) & 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      rst = ($urandom_range(0, 99) == 0);
      tick(r, rst);
      n_total++;
      if (grant !== m_grant() || grant_valid !== (m_owner >= 0) ||
          (m_owner >= 0 && grant_idx !== 3'(m_owner)) || timeout !== m_to)
        $display("FAIL random cycle %0d: req=%b grant=%b valid=%b idx=%0d to=%b required grant=%b to=%b",
                 k, r, grant, grant_valid, grant_idx, timeout, m_grant(), m_to);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_round_robin_arbiter

`default_nettype wire
